// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the BAR-request to register-bus master.
package reg_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CPL   = 2'd3
  } state_t;

  localparam logic [1:0]  CPL_OK   = 2'b00;
  localparam logic [1:0]  CPL_ERR  = 2'b01;
  localparam logic [1:0]  CPL_TMO  = 2'b10;
  localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/reg_bus_watchdog.sv
// WAIT-state watchdog: counts enabled cycles after a clear and flags expiry.
// Only present when REG_BUS_TIMEOUT_EN is defined.
`ifdef REG_BUS_TIMEOUT_EN
module reg_bus_watchdog
  import reg_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clockCore,
  input  logic resetCore,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned      CW   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0]    LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expire = i_enable && (r_count == LAST);

endmodule
`endif

// File: rtl/bar_reg_bus_master.sv
// BAR read/write request to register-bus master, one transaction outstanding.
// Optional WAIT-state abort enabled by defining REG_BUS_TIMEOUT_EN.
module bar_reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clockCore,
  input  logic        resetCore,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqWriteData,
  input  logic [7:0]  reqTag,
  output logic        cplValid,
  input  logic        cplReady,
  output logic [31:0] cplData,
  output logic [7:0]  cplTag,
  output logic [1:0]  cplStatus,
  output logic        registerSelect,
  output logic        registerRead,
  output logic [31:0] registerAddress,
  output logic [31:0] registerWriteData,
  input  logic        registerAck,
  input  logic        registerError,
  input  logic [31:0] registerReadData,
  output logic [15:0] timeoutCount
);

  state_t      r_state;
  logic        r_reqReady;
  logic        r_write;
  logic [7:0]  r_tag;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_select;
  logic        r_read;
  logic        r_cplValid;
  logic [31:0] r_cplData;
  logic [7:0]  r_cplTag;
  logic [1:0]  r_cplStatus;
  logic [31:0] w_reqAddr;
  logic        w_unused;

  always_comb begin
    w_reqAddr = '0;
    w_reqAddr[ADDR_WIDTH-1:2] = reqAddress[ADDR_WIDTH-1:2];
  end

`ifdef REG_BUS_TIMEOUT_EN
  logic        w_expire;
  logic [15:0] r_tmoCount;

  reg_bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clockCore (clockCore),
    .resetCore (resetCore),
    .i_clear   (r_state == ST_ISSUE),
    .i_enable  (r_state == ST_WAIT),
    .o_expire  (w_expire)
  );

  assign timeoutCount = r_tmoCount;
  assign w_unused     = ^{reqAddress[31:ADDR_WIDTH], reqAddress[1:0]};
`else
  assign timeoutCount = '0;
  assign w_unused     = ^{reqAddress[31:ADDR_WIDTH], reqAddress[1:0], (TIMEOUT_CYCLES != 0)};
`endif

  // Select/read are registered in ISSUE so they appear for exactly the first WAIT cycle.
  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      r_state     <= ST_IDLE;
      r_reqReady  <= 1'b0;
      r_write     <= 1'b0;
      r_tag       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_select    <= 1'b0;
      r_read      <= 1'b0;
      r_cplValid  <= 1'b0;
      r_cplData   <= '0;
      r_cplTag    <= '0;
      r_cplStatus <= '0;
`ifdef REG_BUS_TIMEOUT_EN
      r_tmoCount  <= '0;
`endif
    end else begin
      r_select <= 1'b0;
      r_read   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (reqValid && r_reqReady) begin
            r_write    <= reqWrite;
            r_addr     <= w_reqAddr;
            r_wdata    <= reqWriteData;
            r_tag      <= reqTag;
            r_reqReady <= 1'b0;
            r_state    <= ST_ISSUE;
          end else begin
            r_reqReady <= 1'b1;
          end
        end
        ST_ISSUE: begin
          r_select <= 1'b1;
          r_read   <= ~r_write;
          r_state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (registerAck) begin
            if (r_write) begin
              r_reqReady <= 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              r_cplValid  <= 1'b1;
              r_cplData   <= registerError ? ERR_DATA : registerReadData;
              r_cplStatus <= registerError ? CPL_ERR : CPL_OK;
              r_cplTag    <= r_tag;
              r_state     <= ST_CPL;
            end
          end
`ifdef REG_BUS_TIMEOUT_EN
          else if (w_expire) begin
            if (r_tmoCount != '1) r_tmoCount <= r_tmoCount + 16'd1;
            if (r_write) begin
              r_reqReady <= 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              r_cplValid  <= 1'b1;
              r_cplData   <= ERR_DATA;
              r_cplStatus <= CPL_TMO;
              r_cplTag    <= r_tag;
              r_state     <= ST_CPL;
            end
          end
`endif
        end
        ST_CPL: begin
          if (cplReady) begin
            r_cplValid <= 1'b0;
            r_reqReady <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_reqReady <= 1'b0;
        end
      endcase
    end
  end

  assign reqReady          = r_reqReady;
  assign cplValid          = r_cplValid;
  assign cplData           = r_cplData;
  assign cplTag            = r_cplTag;
  assign cplStatus         = r_cplStatus;
  assign registerSelect    = r_select;
  assign registerRead      = r_read;
  assign registerAddress   = r_addr;
  assign registerWriteData = r_wdata;

endmodule

// File: tb/tb_bar_reg_bus_master.sv
// Directed self-checking bench for bar_reg_bus_master (timeout scenarios need REG_BUS_TIMEOUT_EN).
module tb_bar_reg_bus_master;

  logic        clockCore = 1'b0;
  logic        resetCore = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWrite = 1'b0;
  logic [31:0] reqAddress = '0;
  logic [31:0] reqWriteData = '0;
  logic [7:0]  reqTag = '0;
  logic        cplValid;
  logic        cplReady = 1'b0;
  logic [31:0] cplData;
  logic [7:0]  cplTag;
  logic [1:0]  cplStatus;
  logic        registerSelect;
  logic        registerRead;
  logic [31:0] registerAddress;
  logic [31:0] registerWriteData;
  logic        registerAck = 1'b0;
  logic        registerError = 1'b0;
  logic [31:0] registerReadData = '0;
  logic [15:0] timeoutCount;

  int n_cmp = 0;
  int n_mis = 0;
  int sel_cnt = 0;

  bar_reg_bus_master #(
    .ADDR_WIDTH     (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clockCore         (clockCore),
    .resetCore         (resetCore),
    .reqValid          (reqValid),
    .reqReady          (reqReady),
    .reqWrite          (reqWrite),
    .reqAddress        (reqAddress),
    .reqWriteData      (reqWriteData),
    .reqTag            (reqTag),
    .cplValid          (cplValid),
    .cplReady          (cplReady),
    .cplData           (cplData),
    .cplTag            (cplTag),
    .cplStatus         (cplStatus),
    .registerSelect    (registerSelect),
    .registerRead      (registerRead),
    .registerAddress   (registerAddress),
    .registerWriteData (registerWriteData),
    .registerAck       (registerAck),
    .registerError     (registerError),
    .registerReadData  (registerReadData),
    .timeoutCount      (timeoutCount)
  );

  always #5 clockCore = ~clockCore;

  always @(negedge clockCore) if (registerSelect === 1'b1) sel_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  // Present a request at a negedge; returns at the negedge after the accepting edge.
  task automatic send_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [7:0] t);
    int unsigned k = 0;
    reqValid = 1'b1; reqWrite = wr; reqAddress = a; reqWriteData = d; reqTag = t;
    while (reqReady !== 1'b1 && k < 50) begin @(negedge clockCore); k++; end
    if (reqReady !== 1'b1) begin
      n_cmp++; n_mis++;
      $display("FAIL accept_timeout: reqReady=%b required 1", reqReady);
    end
    @(negedge clockCore);
    reqValid = 1'b0;
  endtask

  task automatic wait_select(output int unsigned k);
    k = 0;
    while (registerSelect !== 1'b1 && k < 50) begin @(negedge clockCore); k++; end
    if (registerSelect !== 1'b1) begin
      n_cmp++; n_mis++;
      $display("FAIL select_timeout: registerSelect=%b required 1", registerSelect);
    end
  endtask

  task automatic ack_after(input int unsigned d, input logic err, input logic [31:0] data);
    repeat (d) @(negedge clockCore);
    registerAck = 1'b1; registerError = err; registerReadData = data;
    @(negedge clockCore);
    registerAck = 1'b0; registerError = 1'b0; registerReadData = '0;
  endtask

  task automatic release_cpl();
    cplReady = 1'b1;
    @(negedge clockCore);
    cplReady = 1'b0;
  endtask

  task automatic test_reset();
    logic [125:0] v;
    repeat (2) @(negedge clockCore);
    v = {reqReady, cplValid, cplData, cplTag, cplStatus, registerSelect, registerRead,
         registerAddress, registerWriteData, timeoutCount};
    n_cmp++;
    if (v !== '0) begin n_mis++; $display("FAIL reset_outputs: got %h required 0", v); end
    resetCore = 1'b1;
    @(negedge clockCore);
    n_cmp++;
    if (reqReady !== 1'b1) begin n_mis++; $display("FAIL reset_ready: got %b required 1", reqReady); end
  endtask

  task automatic test_read();
    int unsigned k;
    sel_cnt = 0;
    send_req(1'b0, 32'h0001_0404, 32'h0, 8'h5A);
    n_cmp++;
    if (registerAddress !== 32'h0000_0404) begin
      n_mis++; $display("FAIL read_addr: got %h required 00000404", registerAddress);
    end
    wait_select(k);
    n_cmp++;
    if (k != 1) begin n_mis++; $display("FAIL read_select_time: got %0d required 1", k); end
    n_cmp++;
    if (registerRead !== 1'b1) begin n_mis++; $display("FAIL read_rd: got %b required 1", registerRead); end
    ack_after(4, 1'b0, 32'hCAFE_F00D);
    n_cmp++;
    if ({cplValid, cplData, cplTag, cplStatus} !== {1'b1, 32'hCAFE_F00D, 8'h5A, 2'b00}) begin
      n_mis++;
      $display("FAIL read_cpl: got v=%b d=%h t=%h s=%b required v=1 d=cafef00d t=5a s=00",
               cplValid, cplData, cplTag, cplStatus);
    end
    n_cmp++;
    if (sel_cnt != 1) begin n_mis++; $display("FAIL read_select_count: got %0d required 1", sel_cnt); end
    n_cmp++;
    if (reqReady !== 1'b0) begin n_mis++; $display("FAIL read_ready_in_cpl: got %b required 0", reqReady); end
    release_cpl();
    n_cmp++;
    if ({cplValid, reqReady} !== 2'b01) begin
      n_mis++; $display("FAIL read_release: got valid/ready=%b required 01", {cplValid, reqReady});
    end
  endtask

  task automatic test_write();
    int unsigned k;
    sel_cnt = 0;
    send_req(1'b1, 32'h0000_0010, 32'h1234_5678, 8'h33);
    wait_select(k);
    n_cmp++;
    if ({registerRead, registerAddress, registerWriteData} !== {1'b0, 32'h10, 32'h1234_5678}) begin
      n_mis++;
      $display("FAIL write_bus: got rd=%b a=%h d=%h required rd=0 a=00000010 d=12345678",
               registerRead, registerAddress, registerWriteData);
    end
    n_cmp++;
    if (reqReady !== 1'b0) begin n_mis++; $display("FAIL write_ready_busy: got %b required 0", reqReady); end
    ack_after(2, 1'b1, 32'hDEAD_BEEF);
    n_cmp++;
    if (reqReady !== 1'b1) begin n_mis++; $display("FAIL write_ready_after_ack: got %b required 1", reqReady); end
    repeat (3) @(negedge clockCore);
    n_cmp++;
    if (cplValid !== 1'b0) begin n_mis++; $display("FAIL write_no_cpl: got %b required 0", cplValid); end
    n_cmp++;
    if (sel_cnt != 1) begin n_mis++; $display("FAIL write_select_count: got %0d required 1", sel_cnt); end
  endtask

  task automatic test_read_error();
    int unsigned k;
    send_req(1'b0, 32'h0000_0100, 32'h0, 8'hA7);
    wait_select(k);
    ack_after(1, 1'b1, 32'h1234_0000);
    n_cmp++;
    if ({cplValid, cplData, cplTag, cplStatus} !== {1'b1, 32'hFFFF_FFFF, 8'hA7, 2'b01}) begin
      n_mis++;
      $display("FAIL err_cpl_latency3: got v=%b d=%h t=%h s=%b required v=1 d=ffffffff t=a7 s=01",
               cplValid, cplData, cplTag, cplStatus);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clockCore);
      n_cmp++;
      if ({cplValid, cplData, cplTag, cplStatus, reqReady} !==
          {1'b1, 32'hFFFF_FFFF, 8'hA7, 2'b01, 1'b0}) begin
        n_mis++;
        $display("FAIL err_cpl_hold[%0d]: got v=%b d=%h t=%h s=%b r=%b required 1/ffffffff/a7/01/0",
                 i, cplValid, cplData, cplTag, cplStatus, reqReady);
      end
    end
    release_cpl();
    n_cmp++;
    if (cplValid !== 1'b0) begin n_mis++; $display("FAIL err_release: got %b required 0", cplValid); end
  endtask

`ifdef REG_BUS_TIMEOUT_EN
  task automatic test_timeout();
    int unsigned k;
    send_req(1'b0, 32'h0000_0200, 32'h0, 8'hC3);
    wait_select(k);
    repeat (7) @(negedge clockCore);
    n_cmp++;
    if (cplValid !== 1'b0) begin n_mis++; $display("FAIL tmo_early: got %b required 0", cplValid); end
    @(negedge clockCore);
    n_cmp++;
    if ({cplValid, cplData, cplTag, cplStatus, timeoutCount} !==
        {1'b1, 32'hFFFF_FFFF, 8'hC3, 2'b10, 16'd1}) begin
      n_mis++;
      $display("FAIL tmo_cpl: got v=%b d=%h t=%h s=%b n=%0d required 1/ffffffff/c3/10/1",
               cplValid, cplData, cplTag, cplStatus, timeoutCount);
    end
    release_cpl();
    registerAck = 1'b1; registerReadData = 32'h5555_5555;
    @(negedge clockCore);
    registerAck = 1'b0; registerReadData = '0;
    @(negedge clockCore);
    n_cmp++;
    if ({reqReady, cplValid, registerSelect, timeoutCount} !== {3'b100, 16'd1}) begin
      n_mis++;
      $display("FAIL tmo_late_ack: got r=%b v=%b s=%b n=%0d required 1/0/0/1",
               reqReady, cplValid, registerSelect, timeoutCount);
    end
    send_req(1'b0, 32'h0000_0204, 32'h0, 8'hC4);
    wait_select(k);
    ack_after(7, 1'b0, 32'hABCD_0123);
    n_cmp++;
    if ({cplValid, cplData, cplTag, cplStatus, timeoutCount} !==
        {1'b1, 32'hABCD_0123, 8'hC4, 2'b00, 16'd1}) begin
      n_mis++;
      $display("FAIL tmo_ack_wins: got v=%b d=%h t=%h s=%b n=%0d required 1/abcd0123/c4/00/1",
               cplValid, cplData, cplTag, cplStatus, timeoutCount);
    end
    release_cpl();
  endtask
`endif

  task automatic test_back_to_back();
    int unsigned k;
    n_cmp++;
    if (reqReady !== 1'b1) begin n_mis++; $display("FAIL b2b_idle_ready: got %b required 1", reqReady); end
    reqValid = 1'b1; reqWrite = 1'b0; reqAddress = 32'h20; reqTag = 8'h01;
    @(negedge clockCore);
    reqAddress = 32'h24; reqTag = 8'h02;
    n_cmp++;
    if (reqReady !== 1'b0) begin n_mis++; $display("FAIL b2b_busy_ready: got %b required 0", reqReady); end
    wait_select(k);
    n_cmp++;
    if (registerAddress !== 32'h20) begin
      n_mis++; $display("FAIL b2b_first_addr: got %h required 00000020", registerAddress);
    end
    ack_after(1, 1'b0, 32'h0000_AAAA);
    n_cmp++;
    if ({reqReady, cplValid, cplTag, cplData} !== {2'b01, 8'h01, 32'h0000_AAAA}) begin
      n_mis++;
      $display("FAIL b2b_first_cpl: got r=%b v=%b t=%h d=%h required 0/1/01/0000aaaa",
               reqReady, cplValid, cplTag, cplData);
    end
    cplReady = 1'b1;
    @(negedge clockCore);
    cplReady = 1'b0;
    n_cmp++;
    if ({cplValid, reqReady} !== 2'b01) begin
      n_mis++; $display("FAIL b2b_reopen: got valid/ready=%b required 01", {cplValid, reqReady});
    end
    @(negedge clockCore);
    reqValid = 1'b0;
    n_cmp++;
    if ({reqReady, registerAddress} !== {1'b0, 32'h24}) begin
      n_mis++;
      $display("FAIL b2b_second_accept: got r=%b a=%h required 0/00000024", reqReady, registerAddress);
    end
    wait_select(k);
    ack_after(1, 1'b0, 32'h0000_BBBB);
    n_cmp++;
    if ({cplValid, cplTag, cplData} !== {1'b1, 8'h02, 32'h0000_BBBB}) begin
      n_mis++;
      $display("FAIL b2b_second_cpl: got v=%b t=%h d=%h required 1/02/0000bbbb", cplValid, cplTag, cplData);
    end
    release_cpl();
  endtask

  task automatic test_reset_mid();
    int unsigned k;
    logic [125:0] v;
    send_req(1'b0, 32'h0000_0300, 32'h0, 8'h77);
    wait_select(k);
    @(negedge clockCore);
    resetCore = 1'b0;
    #1;
    v = {reqReady, cplValid, cplData, cplTag, cplStatus, registerSelect, registerRead,
         registerAddress, registerWriteData, timeoutCount};
    n_cmp++;
    if (v !== '0) begin n_mis++; $display("FAIL midreset_outputs: got %h required 0", v); end
    repeat (2) @(negedge clockCore);
    resetCore = 1'b1;
    @(negedge clockCore);
    n_cmp++;
    if ({reqReady, cplValid} !== 2'b10) begin
      n_mis++; $display("FAIL midreset_idle: got ready/valid=%b required 10", {reqReady, cplValid});
    end
    send_req(1'b0, 32'h0000_0304, 32'h0, 8'h78);
    wait_select(k);
    ack_after(1, 1'b0, 32'h600D_F00D);
    n_cmp++;
    if ({cplValid, cplTag, cplData, cplStatus} !== {1'b1, 8'h78, 32'h600D_F00D, 2'b00}) begin
      n_mis++;
      $display("FAIL midreset_next: got v=%b t=%h d=%h s=%b required 1/78/600df00d/00",
               cplValid, cplTag, cplData, cplStatus);
    end
    release_cpl();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_read_error();
`ifdef REG_BUS_TIMEOUT_EN
    test_timeout();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
